// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-port requester arbiter in front of a single shared 32-bit ALU.
//            Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration,
//            otherwise port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu32 (
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result,
    output logic        o_zero
);
    localparam logic [3:0] c_OP_SUB = 4'b0000;
    localparam logic [3:0] c_OP_SRL = 4'b0001;
    localparam logic [3:0] c_OP_LUI = 4'b0010;
    localparam logic [3:0] c_OP_ADD = 4'b0011;
    localparam logic [3:0] c_OP_SLL = 4'b0101;
    localparam logic [3:0] c_OP_OR  = 4'b0110;

    always_comb begin
        o_result = 32'd0;
        case (i_op)
            c_OP_ADD: o_result = i_a + i_b;
            c_OP_SUB: o_result = i_a - i_b;
            c_OP_OR:  o_result = i_a | i_b;
            c_OP_LUI: o_result = {i_b[15:0], 16'h0000};
            c_OP_SLL: o_result = i_b << i_shamt;
            c_OP_SRL: o_result = i_b >> i_shamt;
            default:  o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);
endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    input  logic [3:0]  req0_op_i,
    input  logic [3:0]  req1_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    input  logic [4:0]  req0_shamt_i,
    input  logic [4:0]  req1_shamt_i,
    output logic        rsp0_valid_o,
    output logic        rsp1_valid_o,
    input  logic        rsp0_ready_i,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_zero_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_grant;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_shamt;
    logic [31:0] r_result;
    logic        r_zero;

    logic        w_grant;
    logic        w_accept;
    logic        w_rsp_ready;
    logic [31:0] w_alu_result;
    logic        w_alu_zero;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // r_rr_ptr names the port that wins the next tie.
    logic r_rr_ptr;

    always_comb begin
        w_grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            w_grant = r_rr_ptr;
        end else if (req1_valid_i) begin
            w_grant = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_grant;
        end
    end
`else
    assign w_grant = ~req0_valid_i;
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_rsp_ready  = r_grant ? rsp1_ready_i : rsp0_ready_i;
        case (r_state)
            S_IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: w_state_next = S_RESP;
            S_RESP: begin
                if (w_rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (reset) begin
            w_accept = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= 1'b0;
            r_op     <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_shamt  <= 5'd0;
            r_result <= 32'd0;
            r_zero   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_grant <= w_grant;
                r_op    <= w_grant ? req1_op_i    : req0_op_i;
                r_a     <= w_grant ? req1_a_i     : req0_a_i;
                r_b     <= w_grant ? req1_b_i     : req0_b_i;
                r_shamt <= w_grant ? req1_shamt_i : req0_shamt_i;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu_result;
                r_zero   <= w_alu_zero;
            end
        end
    end

    alu32 u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_shamt  (r_shamt),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    // Outputs are forced quiet while reset is high, even before the reset edge.
    assign req0_ready_o = w_accept & ~w_grant;
    assign req1_ready_o = w_accept &  w_grant;
    assign rsp0_valid_o = ~reset & (r_state == S_RESP) & ~r_grant;
    assign rsp1_valid_o = ~reset & (r_state == S_RESP) &  r_grant;
    assign busy_o       = ~reset & (r_state != S_IDLE);
    assign rsp_data_o   = reset ? 32'd0 : r_result;
    assign rsp_zero_o   = reset ? 1'b1  : r_zero;
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter, directed and random requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    logic        clk;
    logic        reset;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [3:0]  req0_op_i, req1_op_i;
    logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic [4:0]  req0_shamt_i, req1_shamt_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic        rsp0_ready_i, rsp1_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_zero_o;
    logic        busy_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_pri = 0;

    logic [3:0]  op [2];
    logic [31:0] a  [2];
    logic [31:0] b  [2];
    logic [4:0]  sh [2];
    logic        v  [2];
    logic        rr [2];

    alu_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid_i (req0_valid_i),
        .req1_valid_i (req1_valid_i),
        .req0_ready_o (req0_ready_o),
        .req1_ready_o (req1_ready_o),
        .req0_op_i    (req0_op_i),
        .req1_op_i    (req1_op_i),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .req0_shamt_i (req0_shamt_i),
        .req1_shamt_i (req1_shamt_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp0_ready_i (rsp0_ready_i),
        .rsp1_ready_i (rsp1_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_zero_o   (rsp_zero_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] f_op, input logic [31:0] f_a,
                                            input logic [31:0] f_b, input logic [4:0] f_sh);
        case (f_op)
            4'b0011: return f_a + f_b;
            4'b0000: return f_a - f_b;
            4'b0110: return f_a | f_b;
            4'b0010: return f_b * 32'h10000;
            4'b0101: return f_b * (32'd1 << f_sh);
            4'b0001: return f_b / (32'd1 << f_sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req0_valid_i = v[0];  req1_valid_i = v[1];
        req0_op_i    = op[0]; req1_op_i    = op[1];
        req0_a_i     = a[0];  req1_a_i     = a[1];
        req0_b_i     = b[0];  req1_b_i     = b[1];
        req0_shamt_i = sh[0]; req1_shamt_i = sh[1];
        rsp0_ready_i = rr[0]; rsp1_ready_i = rr[1];
    endtask

    task automatic rand_port(input int p);
        logic [3:0] tbl [7];
        tbl = '{4'b0011, 4'b0000, 4'b0110, 4'b0010, 4'b0101, 4'b0001, 4'b1111};
        op[p] = tbl[$urandom_range(0, 6)];
        if ($urandom_range(0, 7) == 0) op[p] = 4'($urandom);
        a[p]  = $urandom;
        b[p]  = ($urandom_range(0, 3) == 0) ? a[p] : $urandom;
        sh[p] = 5'($urandom);
    endtask

    // One complete request/response; the winner is predicted from the policy.
    task automatic txn(input logic v0, input logic v1, input int hold, input bit keep);
        int          win;
        logic [31:0] exp_d;
        win = v1 && !v0 ? 1 : 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (v0 && v1) win = model_pri;
`endif
        exp_d   = alu_ref(op[win], a[win], b[win], sh[win]);
        v[0]    = v0;
        v[1]    = v1;
        rr[win] = (hold == 0);
        rr[1 - win] = 1'b1;
        drive();
        #1;
        chk("idle_ready0", 32'(req0_ready_o), 32'(win == 0));
        chk("idle_ready1", 32'(req1_ready_o), 32'(win == 1));
        chk("idle_busy", 32'(busy_o), 32'd0);
        model_pri = 1 - win;
        tick();
        v[win] = keep;
        if (!keep) rand_port(win);
        drive();
        #1;
        chk("exec_busy", 32'(busy_o), 32'd1);
        chk("exec_ready", 32'({req0_ready_o, req1_ready_o}), 32'd0);
        chk("exec_rsp_valid", 32'({rsp0_valid_o, rsp1_valid_o}), 32'd0);
        tick();
        for (int i = 0; i < hold; i++) begin
            chk("hold_rsp0_valid", 32'(rsp0_valid_o), 32'(win == 0));
            chk("hold_data", rsp_data_o, exp_d);
            tick();
        end
        chk("resp_rsp0_valid", 32'(rsp0_valid_o), 32'(win == 0));
        chk("resp_rsp1_valid", 32'(rsp1_valid_o), 32'(win == 1));
        chk("resp_data", rsp_data_o, exp_d);
        chk("resp_zero", 32'(rsp_zero_o), 32'(exp_d == 32'd0));
        chk("resp_ready", 32'({req0_ready_o, req1_ready_o}), 32'd0);
        rr[win] = 1'b1;
        drive();
        tick();
        chk("done_busy", 32'(busy_o), 32'd0);
        chk("done_rsp_valid", 32'({rsp0_valid_o, rsp1_valid_o}), 32'd0);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            op[p] = 4'd0; a[p] = 32'd0; b[p] = 32'd0; sh[p] = 5'd0; v[p] = 1'b1; rr[p] = 1'b0;
        end
        reset = 1'b1;
        drive();
        tick();
        tick();
        chk("rst_ready", 32'({req0_ready_o, req1_ready_o}), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rsp_valid", 32'({rsp0_valid_o, rsp1_valid_o}), 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        v[0] = 1'b0; v[1] = 1'b0;
        drive();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy_o), 32'd0);

        // ADD on port 0, then SUB on port 1 giving zero
        op[0] = 4'b0011; a[0] = 32'd5; b[0] = 32'd7; sh[0] = 5'd0;
        txn(1'b1, 1'b0, 0, 1'b0);
        op[1] = 4'b0000; a[1] = 32'h1234; b[1] = 32'h1234;
        txn(1'b0, 1'b1, 0, 1'b0);

        // Both ports valid every cycle
        op[0] = 4'b0011; a[0] = 32'd1;    b[0] = 32'd1;
        op[1] = 4'b0110; a[1] = 32'hF0;   b[1] = 32'h0F;
        for (int k = 0; k < 4; k++) txn(1'b1, 1'b1, 0, 1'b1);
        v[0] = 1'b0; v[1] = 1'b0;
        drive();

        // SLL with response held off for 5 cycles, then an undefined op
        op[0] = 4'b0101; a[0] = 32'd0; b[0] = 32'd1; sh[0] = 5'd31;
        txn(1'b1, 1'b0, 5, 1'b0);
        op[0] = 4'b1111; a[0] = 32'd3; b[0] = 32'd4; sh[0] = 5'd0;
        txn(1'b1, 1'b0, 0, 1'b0);
        op[0] = 4'b0011; a[0] = 32'h10; b[0] = 32'h20;
        txn(1'b1, 1'b0, 0, 1'b0);

        // Reset during EXEC of LUI aborts the transaction
        op[0] = 4'b0010; a[0] = 32'd0; b[0] = 32'h0000ABCD;
        v[0] = 1'b1; v[1] = 1'b0; rr[0] = 1'b1; rr[1] = 1'b1;
        drive();
        #1;
        chk("lui_accept", 32'(req0_ready_o), 32'd1);
        tick();
        v[0] = 1'b0;
        drive();
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_rsp_valid", 32'({rsp0_valid_o, rsp1_valid_o}), 32'd0);
        chk("abort_data", rsp_data_o, 32'd0);
        tick();
        reset = 1'b0;
        model_pri = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_replay_valid", 32'({rsp0_valid_o, rsp1_valid_o}), 32'd0);
            chk("no_replay_busy", 32'(busy_o), 32'd0);
        end
        op[0] = 4'b0011; a[0] = 32'd100; b[0] = 32'd23;
        op[1] = 4'b0110; a[1] = 32'hA00;  b[1] = 32'h00B;
        txn(1'b1, 1'b1, 0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            int sel;
            rand_port(0);
            rand_port(1);
            sel = $urandom_range(1, 3);
            txn(sel[0], sel[1], $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
